// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: page-copy DMA engine that freezes the CPU and takes over the memory bus
module dma_bus_arbiter #(
    parameter bit DST_INCREMENT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_read_write,
    output logic        cpu_clk_en,
    output logic [7:0]  cpu_data_in,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_out,
    output logic        mem_read_write,
    input  logic [7:0]  mem_data_in,
    input  logic        dma_start,
    input  logic [7:0]  dma_src_page,
    input  logic [15:0] dma_dst_addr,
    input  logic [7:0]  dma_length,
    output logic        dma_busy,
    output logic        dma_done
);
    typedef enum logic [2:0] {IDLE, WAIT_READ, READ_SRC, WRITE_DST, DONE} state_t;
    state_t state, state_next;
    logic [7:0]  src_page, index, byte_latch;
    logic [15:0] dst_addr;
    logic [8:0]  remaining;
    logic        rd, wr;
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            src_page   <= '0;
            dst_addr   <= '0;
            remaining  <= '0;
            index      <= '0;
            byte_latch <= '0;
        end else begin
            if (state == IDLE && dma_start) begin
                src_page  <= dma_src_page;
                dst_addr  <= dma_dst_addr;
                remaining <= {dma_length == 8'd0, dma_length};
                index     <= '0;
            end
            if (rd) byte_latch <= mem_data_in;
            if (wr) begin
                index     <= index + 8'd1;
                remaining <= remaining - 9'd1;
            end
        end
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = dma_start ? WAIT_READ : IDLE;
            WAIT_READ: state_next = cpu_read_write ? WAIT_READ : READ_SRC;
            READ_SRC:  state_next = WRITE_DST;
            WRITE_DST: state_next = remaining == 9'd1 ? DONE : READ_SRC;
            default:   state_next = IDLE;
        endcase
    end
    assign rd = state == READ_SRC;
    assign wr = state == WRITE_DST;
    // Outside the two stolen states the CPU bus passes straight through.
    assign cpu_clk_en     = !(rd || wr);
    assign cpu_data_in    = mem_data_in;
    assign mem_address    = rd ? {src_page, index}
                          : wr ? (DST_INCREMENT ? dst_addr + {8'h00, index} : dst_addr)
                          : cpu_address;
    assign mem_data_out   = wr ? byte_latch : cpu_data_out;
    assign mem_read_write = rd ? 1'b0 : wr ? 1'b1 : cpu_read_write;
    assign dma_busy       = state == WAIT_READ || rd || wr;
    assign dma_done       = state == DONE;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: vector table, directed corner cases and random copies against a byte-level copy model
module tb_dma_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0, reset_f = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_data_out = '0;
    logic        cpu_read_write = 1'b0;
    logic        dma_start = 1'b0;
    logic [7:0]  dma_src_page = '0, dma_length = '0;
    logic [15:0] dma_dst_addr = '0;
    logic        cpu_clk_en, mem_read_write, dma_busy, dma_done;
    logic [7:0]  cpu_data_in, mem_data_out, mem_data_in;
    logic [15:0] mem_address;
    logic        cpu_clk_en_f, mem_read_write_f, dma_busy_f, dma_done_f;
    logic [7:0]  cpu_data_in_f, mem_data_out_f, mem_data_in_f;
    logic [15:0] mem_address_f;
    logic [7:0]  mem [65536];
    bit          mem_v [65536];
    logic [7:0]  mem_f [65536];
    bit          mem_vf [65536];
    logic [7:0]  ref_mem [65536];
    bit          ref_v [65536];
    logic [23:0] wlog[$], wlog_f[$];
    int cyc = 0, frz = 0, runs = 0, dones = 0, dones_f = 0;
    logic en_q = 1'b1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ (a[15:8] * 8'd29) ^ 8'h3C;
    endfunction

    assign mem_data_in   = mem_v[mem_address] ? mem[mem_address] : pat(mem_address);
    assign mem_data_in_f = mem_vf[mem_address_f] ? mem_f[mem_address_f] : pat(mem_address_f);

    dma_bus_arbiter dut (
        .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
        .cpu_read_write(cpu_read_write), .cpu_clk_en(cpu_clk_en), .cpu_data_in(cpu_data_in),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_read_write(mem_read_write),
        .mem_data_in(mem_data_in), .dma_start(dma_start), .dma_src_page(dma_src_page),
        .dma_dst_addr(dma_dst_addr), .dma_length(dma_length), .dma_busy(dma_busy), .dma_done(dma_done)
    );
    dma_bus_arbiter #(.DST_INCREMENT(1'b0)) dut_f (
        .clk(clk), .reset(reset_f), .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
        .cpu_read_write(cpu_read_write), .cpu_clk_en(cpu_clk_en_f), .cpu_data_in(cpu_data_in_f),
        .mem_address(mem_address_f), .mem_data_out(mem_data_out_f), .mem_read_write(mem_read_write_f),
        .mem_data_in(mem_data_in_f), .dma_start(dma_start), .dma_src_page(dma_src_page),
        .dma_dst_addr(dma_dst_addr), .dma_length(dma_length), .dma_busy(dma_busy_f), .dma_done(dma_done_f)
    );

    // Memory arrays and bus observers, updated mid-cycle when outputs are stable
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_read_write) begin
            mem[mem_address]   <= mem_data_out;
            mem_v[mem_address] <= 1'b1;
            if (!cpu_clk_en) wlog.push_back({mem_address, mem_data_out});
        end
        if (!cpu_clk_en) frz <= frz + 1;
        if (!cpu_clk_en && en_q) runs <= runs + 1;
        en_q <= cpu_clk_en;
        if (dma_done) dones <= dones + 1;
    end
    always @(negedge clk) begin
        if (mem_read_write_f) begin
            mem_f[mem_address_f]  <= mem_data_out_f;
            mem_vf[mem_address_f] <= 1'b1;
            if (!cpu_clk_en_f) wlog_f.push_back({mem_address_f, mem_data_out_f});
        end
        if (dma_done_f) dones_f <= dones_f + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_v[a] ? ref_mem[a] : pat(a);
    endfunction

    task automatic ref_wr(input logic [15:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        ref_v[a] = 1'b1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_address = a;
        cpu_data_out = d;
        cpu_read_write = 1'b1;
        step();
        ref_wr(a, d);
        cpu_read_write = 1'b0;
    endtask

    // One whole copy: start, optional CPU writes while waiting, then the stolen window and DONE
    task automatic xfer(input logic [7:0] page, input logic [15:0] dst, input logic [7:0] len,
                        input int pre_w, input int restart);
        int n, base, f0, r0, d0, j, bad;
        logic [15:0] hold, s, d;
        logic [7:0] v;
        logic [23:0] exp_q[$];
        n = (len == 8'd0) ? 256 : int'(len);
        hold = 16'hC000 + 16'($urandom_range(0, 255));
        base = wlog.size();
        f0 = frz;
        r0 = runs;
        d0 = dones;
        cpu_address = hold;
        cpu_read_write = 1'b0;
        dma_src_page = page;
        dma_dst_addr = dst;
        dma_length = len;
        dma_start = 1'b1;
        step();
        dma_start = 1'b0;
        check("wait_busy", dma_busy, 1);
        for (int w = 0; w < pre_w; w++) begin
            check("wait_clk_en", cpu_clk_en, 1);
            cpu_write(16'h9000 + 16'(w), 8'($urandom));
            check("cpu_write_landed", mem[16'h9000 + 16'(w)], ref_rd(16'h9000 + 16'(w)));
        end
        cpu_address = hold;
        step();
        check("first_read_clk_en", cpu_clk_en, 0);
        check("first_read_addr", {mem_read_write, mem_address}, {1'b0, page, 8'h00});
        for (int i = 0; i < n; i++) begin
            s = {page, 8'(i)};
            d = dst + 16'(i);
            v = ref_rd(s);
            ref_wr(d, v);
            exp_q.push_back({d, v});
        end
        j = 0;
        while (!dma_done && j < 600) begin
            if (j == restart) begin
                dma_src_page = 8'hEE;
                dma_dst_addr = 16'hE000;
                dma_start = 1'b1;
            end
            step();
            dma_start = 1'b0;
            j++;
        end
        check("frozen_cycles", j, 2 * n);
        check("done_busy", dma_busy, 0);
        check("done_clk_en", cpu_clk_en, 1);
        check("resume_addr", mem_address, hold);
        if (restart >= 0) dma_start = 1'b1;
        step();
        dma_start = 1'b0;
        check("after_done", {dma_done, dma_busy, cpu_clk_en}, 3'b001);
        if (restart >= 0) begin
            step();
            check("restart_ignored", dma_busy, 0);
        end
        check("write_count", wlog.size() - base, n);
        bad = -1;
        for (int i = 0; i < n && base + i < wlog.size(); i++)
            if (bad < 0 && wlog[base + i] !== exp_q[i]) bad = i;
        check("write_data_first_bad_idx", bad, 32'hFFFF_FFFF);
        check("frozen_total", frz - f0, 2 * n);
        check("frozen_runs", runs - r0, 1);
        check("done_pulses", dones - d0, 1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        logic        exp_rw;
        logic        exp_en;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int base, d0, f0, fb;
        logic [7:0] e0, e1;
        vecs[0] = '{16'h8000, 8'h11, 1'b1, 16'h8000, 8'h11, 1'b1, 1'b1};
        vecs[1] = '{16'h8000, 8'h22, 1'b0, 16'h8000, 8'h22, 1'b0, 1'b1};
        vecs[2] = '{16'hFFFF, 8'h5A, 1'b1, 16'hFFFF, 8'h5A, 1'b1, 1'b1};
        vecs[3] = '{16'h0001, 8'hA5, 1'b0, 16'h0001, 8'hA5, 1'b0, 1'b1};
        vecs[4] = '{16'h8001, 8'h00, 1'b1, 16'h8001, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{16'h8001, 8'hFF, 1'b0, 16'h8001, 8'hFF, 1'b0, 1'b1};

        // Reset state, with the write pass-through parked on a scratch byte
        cpu_address = 16'h8F00;
        cpu_data_out = 8'h00;
        cpu_read_write = 1'b1;
        step();
        step();
        ref_wr(16'h8F00, 8'h00);
        check("rst_clk_en", cpu_clk_en, 1);
        check("rst_busy_done", {dma_busy, dma_done}, 2'b00);
        check("rst_rw_pass_hi", mem_read_write, 1);
        cpu_read_write = 1'b0;
        #1;
        check("rst_rw_pass_lo", mem_read_write, 0);
        reset = 1'b1;
        step();

        foreach (vecs[i]) begin
            cpu_address = vecs[i].a;
            cpu_data_out = vecs[i].d;
            cpu_read_write = vecs[i].rw;
            #2;
            check("idle_addr", mem_address, vecs[i].exp_a);
            check("idle_rw", mem_read_write, vecs[i].exp_rw);
            check("idle_clk_en", cpu_clk_en, vecs[i].exp_en);
            if (vecs[i].rw) check("idle_wdata", mem_data_out, vecs[i].exp_d);
            else check("idle_rdata", cpu_data_in, ref_rd(vecs[i].a));
            step();
            if (vecs[i].rw) ref_wr(vecs[i].a, vecs[i].d);
        end
        cpu_read_write = 1'b0;

        // Four known bytes copied to 0x0300
        cpu_write(16'h2000, 8'hAA);
        cpu_write(16'h2001, 8'hBB);
        cpu_write(16'h2002, 8'hCC);
        cpu_write(16'h2003, 8'hDD);
        xfer(8'h20, 16'h0300, 8'd4, 0, -1);
        check("copy4_b0", mem[16'h0300], 8'hAA);
        check("copy4_b3", mem[16'h0303], 8'hDD);

        // Start while the CPU is writing
        xfer(8'h21, 16'h0400, 8'd2, 3, -1);

        // Fixed destination on the second instance
        reset_f = 1'b1;
        step();
        fb = wlog_f.size();
        d0 = dones_f;
        xfer(8'h70, 16'hD000, 8'd3, 0, -1);
        check("fixed_count", wlog_f.size() - fb, 3);
        for (int i = 0; i < 3; i++)
            if (fb + i < wlog_f.size())
                check("fixed_write", wlog_f[fb + i], {16'hD000, pat({8'h70, 8'(i)})});
        check("fixed_done", dones_f - d0, 1);
        reset_f = 1'b0;
        step();

        // Second start during WRITE_DST and in DONE
        xfer(8'h22, 16'h0500, 8'd2, 0, 1);

        // Reset in the third READ_SRC of an 8-byte copy
        base = wlog.size();
        d0 = dones;
        f0 = frz;
        e0 = ref_rd(16'h5000);
        e1 = ref_rd(16'h5001);
        cpu_address = 16'hC123;
        cpu_read_write = 1'b0;
        dma_src_page = 8'h50;
        dma_dst_addr = 16'h3000;
        dma_length = 8'd8;
        dma_start = 1'b1;
        step();
        dma_start = 1'b0;
        step();
        for (int j = 0; j < 4; j++) step();
        check("rst_mid_in_read", {mem_read_write, mem_address}, {1'b0, 16'h5002});
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rst_mid_idle", {cpu_clk_en, dma_busy, dma_done}, 3'b100);
        check("rst_mid_pass", mem_address, 16'hC123);
        step();
        step();
        step();
        check("rst_mid_busy", dma_busy, 0);
        check("rst_mid_writes", wlog.size() - base, 2);
        if (wlog.size() >= base + 2) begin
            check("rst_mid_w0", wlog[base], {16'h3000, e0});
            check("rst_mid_w1", wlog[base + 1], {16'h3001, e1});
        end
        check("rst_mid_no_done", dones - d0, 0);
        check("rst_mid_frozen", frz - f0, 5);
        ref_wr(16'h3000, e0);
        ref_wr(16'h3001, e1);

        // Random copies
        for (int r = 0; r < 8; r++)
            xfer(8'($urandom_range(16, 95)), 16'($urandom_range(16'h1000, 16'h5FFF)),
                 8'($urandom_range(1, 24)), $urandom_range(0, 2), -1);

        // Full page with destination wrap
        xfer(8'h40, 16'hFF80, 8'd0, 1, -1);
        check("wrap_ffff", mem[16'hFFFF], ref_rd(16'hFFFF));
        check("wrap_0000", mem[16'h0000], pat(16'h4080));
        check("wrap_007f", mem[16'h007F], pat(16'h40FF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Page-copy DMA engine and memory-bus arbiter between `cpu6502` and system memory. On request, it copies 1–256 bytes from a source page to a destination address by stealing the bus: it freezes the CPU through a clock enable and drives memory itself. It sits between the CPU's `address_out`/`data_out`/`READ_write` pins and the memory array. It is the only master of the memory bus.

## Interface
Parameters:
- `DST_INCREMENT`, default 1. 1: destination address increments per byte. 0: destination is fixed (I/O port).

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cpu_address`  in  16  CPU address output.
- `cpu_data_out`  in  8  CPU write data.
- `cpu_read_write`  in  1  CPU direction; 0 = read, 1 = write.
- `cpu_clk_en`  out  1  1 = CPU advances this edge; 0 = CPU frozen.
- `cpu_data_in`  out  8  read data to CPU; always equals `mem_data_in`.
- `mem_address`  out  16  memory address.
- `mem_data_out`  out  8  memory write data.
- `mem_read_write`  out  1  0 = read, 1 = write.
- `mem_data_in`  in  8  memory read data, valid in the same cycle (asynchronous read).
- `dma_start`  in  1  single-cycle request; sampled only in IDLE.
- `dma_src_page`  in  8  source high byte; source = {page, index}.
- `dma_dst_addr`  in  16  destination base address.
- `dma_length`  in  8  byte count; 0 means 256.
- `dma_busy`  out  1  high from the cycle after accepted start through the last WRITE_DST.
- `dma_done`  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, WAIT_READ, READ_SRC, WRITE_DST, DONE.
- IDLE:
  - mem bus = CPU bus (address, data, direction pass-through); `cpu_clk_en`=1.
  - `dma_start`=1 latches src_page, dst_addr and length (0→256 in a 9-bit count), clears index → WAIT_READ.
- WAIT_READ:
  - Bus still owned by CPU; `cpu_clk_en`=1; `dma_busy`=1.
  - If `cpu_read_write`=0 this cycle → READ_SRC. Otherwise stay, so the bus is never taken across a CPU write cycle.
- READ_SRC:
  - `cpu_clk_en`=0, `mem_read_write`=0, `mem_address`={src_page, index}.
  - Capture `mem_data_in` into byte latch → WRITE_DST.
- WRITE_DST:
  - `cpu_clk_en`=0, `mem_read_write`=1, `mem_data_out`=byte latch.
  - `mem_address`=dst_addr+index (16-bit, wraps FFFF→0000) if `DST_INCREMENT`, else dst_addr.
  - index+1, remaining-1.
  - If remaining was 1 → DONE, else → READ_SRC.
- DONE:
  - Bus to CPU, `cpu_clk_en`=1, `dma_done`=1, `dma_busy`=0 → IDLE.
- Source index wraps within the page (8 bits). Length 256 from page 0x12 reads 0x1200–0x12FF.
- The frozen CPU holds its pending cycle and replays it unchanged when `cpu_clk_en` returns to 1.
- `dma_start` outside IDLE is ignored (no queueing). A start in DONE is also ignored.
- Reset (`reset`=0 at an edge) from any state → IDLE. All latches, index and count are cleared.

## Timing
- Reset values: state IDLE, `cpu_clk_en`=1, `dma_busy`=0, `dma_done`=0, `mem_read_write`=`cpu_read_write` (pass-through), byte latch 0.
- Start accepted at edge k → WAIT_READ in cycle k+1. The earliest READ_SRC is cycle k+2.
- N-byte transfer: exactly 2N consecutive cycles with `cpu_clk_en`=0, then one DONE cycle.
- `cpu_clk_en`, `mem_*` and the outputs are decoded from state combinationally. The only combinational input paths are CPU bus pass-through and the `cpu_read_write` test in WAIT_READ.
- Reset mid-transfer: the next cycle is IDLE with `cpu_clk_en`=1. No further DMA writes occur, and no `dma_done` pulse is issued.

## Test plan
- Copy 4 bytes: page 0x20 holding AA,BB,CC,DD to dst 0x0300, CPU reading.
  - → writes 0x0300..0x0303 = AA..DD.
  - → `cpu_clk_en` low exactly 8 cycles, `dma_done` pulse 1 cycle, CPU resumes with its held address.
- Start while the CPU does three consecutive write cycles.
  - → stays WAIT_READ through them, memory receives all three CPU writes.
  - → first READ_SRC in the cycle after the first CPU read.
- Length 0 from page 0x40 to dst 0xFF80, `DST_INCREMENT`=1.
  - → 256 bytes, destination wraps 0xFFFF→0x0000..0x007F, 512 frozen cycles.
- `DST_INCREMENT`=0, length 3, dst 0xD000.
  - → three writes all to 0xD000 with source bytes in order.
- Second `dma_start` during WRITE_DST of a 2-byte copy.
  - → ignored: exactly 2 writes, single `dma_done`, IDLE afterwards.
- `reset`=0 in the third READ_SRC of an 8-byte copy.
  - → IDLE next cycle, `cpu_clk_en`=1, only 2 destination bytes written, `dma_busy`=0, no `dma_done`.
